// File: rtl/kr580_pit.sv
// KR580 port-mapped programmable interval timer: 16-bit down counter with prescaler and
// level interrupt. Optional macro KR580_PIT_LATCH_EN adds a coherent high-byte read latch.
module kr580_pit #(
    parameter logic [7:0]  BASE     = 8'h40,
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] pa,
    input  logic [7:0] po,
    input  logic       pw,
    output logic [7:0] pi,
    output logic       intr,
    input  logic       inta
);
    localparam logic [7:0] PreMax = 8'(PRESCALE - 1);

    logic [15:0] cnt_q, cnt_d, reload_q, reload_d;
    logic [7:0]  shadow_q, shadow_d, presc_q, presc_d, pi_q, pi_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        pend_q, pend_d, intr_q;
    logic [8:0]  ofs_full;
    logic [1:0]  ofs;
    logic        hit, wr, wr_ctrl, commit, tick;
    logic [7:0]  hi_rd;

`ifdef KR580_PIT_LATCH_EN
    logic [7:0] latch_q, latch_d;
    assign hi_rd = latch_q;
`else
    assign hi_rd = cnt_q[15:8];
`endif

    // 9-bit difference keeps addresses below BASE from aliasing into the window
    assign ofs_full = {1'b0, pa} - {1'b0, BASE};
    assign hit      = (ofs_full < 9'd4);
    assign ofs      = ofs_full[1:0];

    always_comb begin
        wr       = pw && hit;
        wr_ctrl  = wr && (ofs == 2'd2);
        commit   = wr && (ofs == 2'd1);
        tick     = ctrl_q[0] && (presc_q == PreMax);

        presc_d  = (ctrl_q[0] && !tick) ? presc_q + 8'd1 : 8'd0;
        if (wr_ctrl) presc_d = 8'd0;

        shadow_d = shadow_q;
        reload_d = reload_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;

        if (wr && (ofs == 2'd0)) shadow_d = po;
        if (commit) reload_d = {po, shadow_q};
        if (wr_ctrl) ctrl_d = po[2:0];
        if (inta || (wr && (ofs == 2'd3) && po[0])) pend_d = 1'b0;

        // A CTRL write in the same cycle discards the tick
        if (tick && !wr_ctrl) begin
            if (cnt_q == 16'd1) begin
                pend_d = 1'b1;
                if (ctrl_q[1]) begin
                    cnt_d = reload_d;
                end else begin
                    cnt_d     = 16'd0;
                    ctrl_d[0] = 1'b0;
                end
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
        if (commit && !ctrl_q[0]) cnt_d = reload_d;

        pi_d = 8'h00;
        if (hit) begin
            case (ofs)
                2'd0:    pi_d = cnt_q[7:0];
                2'd1:    pi_d = hi_rd;
                2'd2:    pi_d = {5'b0, ctrl_q};
                default: pi_d = {7'b0, pend_q};
            endcase
        end
    end

`ifdef KR580_PIT_LATCH_EN
    always_comb begin
        latch_d = latch_q;
        if (hit && (ofs == 2'd0) && !pw) latch_d = cnt_q[15:8];
    end

    always_ff @(posedge clock) begin
        if (reset) latch_q <= 8'h00;
        else       latch_q <= latch_d;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= 16'h0000;
            reload_q <= 16'h0000;
            shadow_q <= 8'h00;
            presc_q  <= 8'h00;
            ctrl_q   <= 3'b000;
            pend_q   <= 1'b0;
            intr_q   <= 1'b0;
            pi_q     <= 8'h00;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            shadow_q <= shadow_d;
            presc_q  <= presc_d;
            ctrl_q   <= ctrl_d;
            pend_q   <= pend_d;
            intr_q   <= pend_q & ctrl_q[2];
            pi_q     <= pi_d;
        end
    end

    assign pi   = pi_q;
    assign intr = intr_q;
endmodule
